// File: rtl/layer_run_sched_pkg.sv
// Shared definitions for the conv-layer run controller: state encoding and datapath widths.
package layer_run_sched_pkg;

  localparam int DW          = 30;
  localparam int A_DSP_WIDTH = 30;
  localparam int B_DSP_WIDTH = 18;

  localparam int FM_W  = 30;
  localparam int W_W   = 18;
  localparam int OUT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_FM = 3'd1,
    ST_LOAD_WT = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_run_sched_bram_rd_skid.sv
// Streams DEPTH words out of a 1-cycle-latency BRAM into a valid/ready port via a 2-entry buffer.
module bram_rd_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_ren,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last,
  output logic              o_last_hs
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                       active_q, active_d;
  logic [CW-1:0]              rd_cnt_q, rd_cnt_d;
  logic                       infl_q, infl_d;
  logic                       infl_last_q, infl_last_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [1:0][DATA_W-1:0]     data_q, data_d;
  logic [1:0]                 last_q, last_d;
  logic                       pop;
  logic [1:0]                 cnt_after;
  logic [1:0]                 occ;

  always_comb begin
    active_d    = active_q;
    rd_cnt_d    = rd_cnt_q;
    data_d      = data_q;
    last_d      = last_q;
    pop         = (cnt_q != 2'd0) && i_m_ready;
    cnt_after   = cnt_q - 2'(pop);
    // Entries held after this cycle plus the read already in flight; a new read must still fit.
    occ         = cnt_after + 2'(infl_q);
    o_ren       = active_q && (rd_cnt_q < CW'(DEPTH)) && (occ <= 2'd1);
    infl_d      = o_ren;
    infl_last_d = o_ren && (rd_cnt_q == CW'(DEPTH - 1));
    o_last_hs   = pop && last_q[0];

    if (pop) begin
      data_d[0] = data_q[1];
      last_d[0] = last_q[1];
    end
    if (infl_q) begin
      if (cnt_after == 2'd0) begin
        data_d[0] = i_rdata;
        last_d[0] = infl_last_q;
      end else begin
        data_d[1] = i_rdata;
        last_d[1] = infl_last_q;
      end
    end
    cnt_d = occ;

    if (o_ren) rd_cnt_d = rd_cnt_q + CW'(1);
    if (i_start) begin
      active_d = 1'b1;
      rd_cnt_d = '0;
    end else if (o_last_hs) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      active_q    <= 1'b0;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      data_q      <= '0;
      last_q      <= '0;
    end else begin
      active_q    <= active_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign o_raddr   = ADDR_W'(rd_cnt_q);
  assign o_m_valid = (cnt_q != 2'd0);
  assign o_m_data  = data_q[0];
  assign o_m_last  = o_m_valid && last_q[0];

endmodule

// File: rtl/layer_run_sched.sv
// Run controller for one conv layer: loads FM/weight BRAMs, runs the layer under a watchdog, drains results.
module layer_run_sched #(
  parameter int FM_SIZE     = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int IN_FM_CH    = 1,
  parameter int OUT_FM_CH   = 6,
  parameter int OUT_SIZE    = 24,
  parameter int FM_W        = layer_run_sched_pkg::FM_W,
  parameter int W_W         = layer_run_sched_pkg::W_W,
  parameter int OUT_W       = layer_run_sched_pkg::OUT_W,
  parameter int TIMEOUT     = 2**20,
  localparam int FM_WORDS   = FM_SIZE * FM_SIZE * IN_FM_CH,
  localparam int WT_WORDS   = KERNEL_SIZE * KERNEL_SIZE * IN_FM_CH * OUT_FM_CH,
  localparam int OUT_WORDS  = OUT_SIZE * OUT_SIZE * OUT_FM_CH,
  localparam int FM_AW      = layer_run_sched_pkg::addr_w(FM_WORDS),
  localparam int WT_AW      = layer_run_sched_pkg::addr_w(WT_WORDS),
  localparam int OUT_AW     = layer_run_sched_pkg::addr_w(OUT_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [FM_W-1:0]   i_s_data,
  input  logic              i_s_last,
  output logic              o_fm_we,
  output logic [FM_AW-1:0]  o_fm_waddr,
  output logic [FM_W-1:0]   o_fm_wdata,
  output logic              o_wt_we,
  output logic [WT_AW-1:0]  o_wt_waddr,
  output logic [W_W-1:0]    o_wt_wdata,
  output logic              o_layer_rst,
  input  logic              i_layer_done,
  output logic              o_out_ren,
  output logic [OUT_AW-1:0] o_out_raddr,
  input  logic [OUT_W-1:0]  i_out_rdata,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [OUT_W-1:0]  o_m_data,
  output logic              o_m_last
);

  import layer_run_sched_pkg::*;

  localparam int TOTAL = FM_WORDS + WT_WORDS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int RUN_W = $clog2(TIMEOUT);
  localparam int GUARD = 2;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                error_q, error_d;
  logic                done_q, done_d;
  logic                fm_we_q, fm_we_d;
  logic [FM_AW-1:0]    fm_waddr_q, fm_waddr_d;
  logic [FM_W-1:0]     fm_wdata_q, fm_wdata_d;
  logic                wt_we_q, wt_we_d;
  logic [WT_AW-1:0]    wt_waddr_q, wt_waddr_d;
  logic [W_W-1:0]      wt_wdata_q, wt_wdata_d;
  logic                beat, last_beat, drain_start, drain_last;

  assign o_s_ready = (state_q == ST_LOAD_FM) || (state_q == ST_LOAD_WT);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    run_cnt_d   = run_cnt_q;
    error_d     = error_q;
    done_d      = 1'b0;
    fm_we_d     = 1'b0;
    fm_waddr_d  = fm_waddr_q;
    fm_wdata_d  = fm_wdata_q;
    wt_we_d     = 1'b0;
    wt_waddr_d  = wt_waddr_q;
    wt_wdata_d  = wt_wdata_q;
    drain_start = 1'b0;
    beat        = i_s_valid && o_s_ready;
    last_beat   = (beat_cnt_q == CNT_W'(TOTAL - 1));

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (i_start) begin
          state_d    = ST_LOAD_FM;
          beat_cnt_d = '0;
          error_d    = 1'b0;
        end
      end
      ST_LOAD_FM, ST_LOAD_WT: begin
        if (beat) begin
          // A misplaced or missing last marker aborts the load without writing the beat.
          if (i_s_last != last_beat) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (state_q == ST_LOAD_FM) begin
              fm_we_d    = 1'b1;
              fm_waddr_d = FM_AW'(beat_cnt_q);
              fm_wdata_d = i_s_data;
              if (beat_cnt_q == CNT_W'(FM_WORDS - 1)) state_d = ST_LOAD_WT;
            end else begin
              wt_we_d    = 1'b1;
              wt_waddr_d = WT_AW'(beat_cnt_q - CNT_W'(FM_WORDS));
              wt_wdata_d = i_s_data[W_W-1:0];
              if (last_beat) begin
                state_d   = ST_RUN;
                run_cnt_d = '0;
              end
            end
          end
        end
      end
      ST_RUN: begin
        if (i_layer_done && (run_cnt_q >= RUN_W'(GUARD))) begin
          state_d     = ST_DRAIN;
          drain_start = 1'b1;
        end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      run_cnt_q  <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      fm_we_q    <= 1'b0;
      fm_waddr_q <= '0;
      fm_wdata_q <= '0;
      wt_we_q    <= 1'b0;
      wt_waddr_q <= '0;
      wt_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      run_cnt_q  <= run_cnt_d;
      error_q    <= error_d;
      done_q     <= done_d;
      fm_we_q    <= fm_we_d;
      fm_waddr_q <= fm_waddr_d;
      fm_wdata_q <= fm_wdata_d;
      wt_we_q    <= wt_we_d;
      wt_waddr_q <= wt_waddr_d;
      wt_wdata_q <= wt_wdata_d;
    end
  end

  bram_rd_skid #(
    .DATA_W (OUT_W),
    .ADDR_W (OUT_AW),
    .DEPTH  (OUT_WORDS)
  ) u_skid (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (drain_start),
    .o_ren     (o_out_ren),
    .o_raddr   (o_out_raddr),
    .i_rdata   (i_out_rdata),
    .o_m_valid (o_m_valid),
    .i_m_ready (i_m_ready),
    .o_m_data  (o_m_data),
    .o_m_last  (o_m_last),
    .o_last_hs (drain_last)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_layer_rst = (state_q != ST_RUN);
  assign o_fm_we     = fm_we_q;
  assign o_fm_waddr  = fm_waddr_q;
  assign o_fm_wdata  = fm_wdata_q;
  assign o_wt_we     = wt_we_q;
  assign o_wt_waddr  = wt_waddr_q;
  assign o_wt_wdata  = wt_wdata_q;

endmodule
